// File: rtl/qtr_line_pos.sv
// qtr_line_pos -- line position estimator for an 8-channel QTR reflectance array.
//
// A finished sensor conversion (QT8..QT1 discharge counts) is captured on a
// start pulse.  Channels whose count is strictly above thr contribute their
// count as a weight.  The weighted mean of the channel positions
// (channel i sits at i*256) is the line position, 0..1792.
//
// Handshake: start is a one-cycle request that is honoured only in IDLE.
// Requests arriving while a conversion is in flight (ACC, DIV or DONE) are
// dropped, not queued.  Each accepted start yields exactly one valid pulse
// 30 cycles after the capture edge.  pos/lost are stable from that pulse
// until the next result.
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   start    one-cycle pulse, QT inputs and thr are valid
//   QT8..QT1 8-bit discharge counts (QT1 = channel 0, QT8 = channel 7)
//   thr      8-bit noise threshold, captured with the QT inputs
//   pos      11-bit registered line position, 0..1792
//   valid    one-cycle pulse, pos and lost were just updated
//   busy     high from the capture edge through the valid cycle
//   lost     no channel exceeded thr in the last conversion
//   on_line  bit i = channel i exceeded thr, updated at capture
//
// LOST_HOLD: 1 = on line loss snap pos to the nearer edge of the last
//            position; 0 = keep the last position.

module qtr_line_pos #(
    parameter bit LOST_HOLD = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  QT8,
    input  logic [7:0]  QT7,
    input  logic [7:0]  QT6,
    input  logic [7:0]  QT5,
    input  logic [7:0]  QT4,
    input  logic [7:0]  QT3,
    input  logic [7:0]  QT2,
    input  logic [7:0]  QT1,
    input  logic [7:0]  thr,
    output logic [10:0] pos,
    output logic        valid,
    output logic        busy,
    output logic        lost,
    output logic [7:0]  on_line
);

    typedef enum logic [1:0] {IDLE, ACC, DIV, DONE} state_t;

    state_t          state;
    logic [4:0]      cnt;       // channel index in ACC, iteration in DIV
    logic [7:0][7:0] val;       // captured effective (thresholded) values
    logic [20:0]     num;       // numerator; becomes the quotient during DIV
    logic [10:0]     den;
    logic [10:0]     rem;       // stays below den, so 11 bits are enough

    logic [7:0][7:0] qt_in;
    logic [7:0][7:0] eff_in;
    logic [7:0]      hit;
    logic [7:0]      v_cur;
    logic [10:0]     prod;
    logic [11:0]     r_sh;
    logic [11:0]     r_sub;
    logic            ge;
    logic [10:0]     q_sat;

    assign qt_in = {QT8, QT7, QT6, QT5, QT4, QT3, QT2, QT1};

    always_comb begin
        eff_in = '0;
        hit    = '0;
        for (int i = 0; i < 8; i++) begin
            hit[i]    = qt_in[i] > thr;
            eff_in[i] = hit[i] ? qt_in[i] : 8'd0;
        end
    end

    // ACC term: v_i * i * 256, formed as (v_i * i) shifted left by 8.
    assign v_cur = val[cnt[2:0]];
    assign prod  = {3'b000, v_cur} * {8'd0, cnt[2:0]};

    // One restoring-division step: shift the next numerator bit into the
    // remainder, subtract den when it fits, and shift the quotient bit into num.
    assign r_sh  = {rem, num[20]};
    assign r_sub = r_sh - {1'b0, den};
    assign ge    = r_sh >= {1'b0, den};

    // The weighted mean cannot exceed 1792 in theory; the clamp keeps pos
    // in range regardless.
    assign q_sat = (num > 21'd1792) ? 11'd1792 : num[10:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            val     <= '0;
            num     <= '0;
            den     <= '0;
            rem     <= '0;
            pos     <= 11'd896;
            valid   <= 1'b0;
            busy    <= 1'b0;
            lost    <= 1'b0;
            on_line <= '0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    // busy stays high through the valid cycle (set in DONE)
                    // and drops here unless a new conversion starts at once.
                    busy <= start;
                    if (start) begin
                        val     <= eff_in;
                        on_line <= hit;
                        num     <= '0;
                        den     <= '0;
                        rem     <= '0;
                        cnt     <= '0;
                        state   <= ACC;
                    end
                end
                ACC: begin
                    busy <= 1'b1;
                    num  <= num + {2'b00, prod, 8'd0};
                    den  <= den + {3'b000, v_cur};
                    if (cnt == 5'd7) begin
                        cnt   <= '0;
                        state <= DIV;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                DIV: begin
                    busy <= 1'b1;
                    rem  <= ge ? r_sub[10:0] : r_sh[10:0];
                    num  <= {num[19:0], ge};
                    if (cnt == 5'd20) begin
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                DONE: begin
                    busy  <= 1'b1;
                    valid <= 1'b1;
                    state <= IDLE;
                    if (den == 11'd0) begin
                        // Divider output is meaningless with a zero divisor.
                        lost <= 1'b1;
                        if (LOST_HOLD) begin
                            pos <= (pos < 11'd896) ? 11'd0 : 11'd1792;
                        end
                    end else begin
                        lost <= 1'b0;
                        pos  <= q_sat;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/qtr_line_pos.md
QTR_LINE_POS -- requirements
Module: qtr_line_pos

Interface
REQ-001 SHALL have parameter LOST_HOLD, default 1; 1 = on line loss, clamp pos to the edge of the last valid position; 0 = hold the last pos.
REQ-002 SHALL have port clk  input  1  system clock; every register updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port start  input  1  one-cycle pulse; QT8..QT1 are valid (sensor array conversion finished).
REQ-005 SHALL have ports QT8,QT7,QT6,QT5,QT4,QT3,QT2,QT1  input  8 each  sensor discharge counts; QT1 = channel index 0, QT8 = channel index 7.
REQ-006 SHALL have port thr  input  8  noise threshold; sampled together with the QT inputs.
REQ-007 SHALL have port pos  output  11  line position, 0..1792, registered.
REQ-008 SHALL have port valid  output  1  one-cycle pulse; pos and lost are updated.
REQ-009 SHALL have port busy  output  1  high from capture until the valid pulse, inclusive.
REQ-010 SHALL have port lost  output  1  no channel exceeded thr in the last conversion.
REQ-011 SHALL have port on_line  output  8  bit i = channel i exceeded thr; updated at capture.

Function
REQ-012 FSM SHALL use states IDLE, ACC, DIV, DONE; IDLE->ACC on start; ACC->DIV after 8 cycles; DIV->DONE after 21 cycles; DONE->IDLE after 1 cycle.
REQ-013 In IDLE with start=1 at edge N, the block SHALL register all QT inputs and thr, and SHALL update on_line.
REQ-014 Effective value v_i SHALL be QTi when QTi > thr (strict), else 0.
REQ-015 ACC SHALL process one channel per cycle, i = 0..7: num += v_i*(i*256) (21-bit), den += v_i (11-bit).
REQ-016 DIV SHALL be a 21-iteration restoring division num/den, with the quotient truncated toward zero and saturated at 1792.
REQ-017 Latency SHALL be fixed regardless of data: pos, lost and valid update at edge N+30; valid is high for exactly that one cycle.
REQ-018 When den = 0, lost SHALL be 1 and the divider result SHALL be discarded.
REQ-019 When lost and LOST_HOLD=1: pos = 0 if previous pos < 896, else 1792.
REQ-020 When lost and LOST_HOLD=0: pos SHALL keep its previous value.
REQ-021 When den != 0: lost = 0, and pos = the quotient.
REQ-022 start SHALL be ignored while busy=1, including in the DONE cycle.
REQ-023 busy SHALL be 1 from edge N through the cycle in which valid=1, and 0 in IDLE.
REQ-024 A start accepted in IDLE the cycle after DONE SHALL begin a new conversion with no gap required.

Reset
REQ-025 While rst=1, state SHALL be IDLE, pos = 896, valid = 0, busy = 0, lost = 0, on_line = 0x00, and accumulators = 0.
REQ-026 rst asserted mid-ACC or mid-DIV SHALL abort the conversion immediately, with no valid pulse; the first start after rst deasserts SHALL be accepted normally.

Verification
REQ-027 QT1=200, others 0, thr=50, start at edge N -> edge N+30: valid=1, pos=0, lost=0, on_line=0x01; valid low at N+31.
REQ-028 QT4=QT5=100, others 0, thr=50 -> pos=896 (179200/200), on_line=0x18.
REQ-029 QT1=100, QT2=50, others 0, thr=10 -> pos=85 (12800/150, truncated); QT8=255 only, thr=10 -> pos=1792.
REQ-030 After pos=1792, all QT=40, thr=40 (equal, not above) -> lost=1, on_line=0x00, pos=1792 (LOST_HOLD=1); with LOST_HOLD=0 -> pos unchanged.
REQ-031 Second start pulse at N+5 -> ignored: exactly one valid, at N+30; a start at N+31 -> valid at N+61.
REQ-032 rst pulse at N+15 (mid-DIV) -> busy=0, pos=896, and no valid pulse; a new start after reset completes with the correct pos 30 cycles later.
